// File: rtl/run_ctrl.sv
// run_ctrl: run/step/halt controller for a processor core.
// A prescaler divides clk by DIV to produce a one-clk processor tick enable.
// The block counts busy ticks, halts on request or on a cycle limit, and
// supports free-run, single-step, abort and clear.
module run_ctrl #(
  parameter int DIV = 4,
  parameter int CW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          step,
  input  logic          clr,
  input  logic          busy,
  input  logic          halt,
  input  logic [CW-1:0] max_cycles,
  output logic          clk_en,
  output logic          running,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Prescaler width; at least one bit so DIV=2 still has a counter.
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PCNT_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] PCNT_ZERO = {PW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW:0]   CMP_ONE   = (CW + 1)'(1'b1);

  // Saturating increment: all-ones sticks rather than wrapping to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          timeout_q, timeout_d;

  logic active_s;
  logic tick_s;
  logic counted_s;
  logic limit_hit_s;

  // Tick decode. Gated by rst so no tick escapes in a reset cycle; the
  // limit compare is one bit wider so a saturated counter cannot alias.
  always_comb begin
    active_s    = (state_q == ST_RUN) || (state_q == ST_STEP);
    tick_s      = rst && active_s && (pcnt_q == PCNT_LAST) && !stop;
    counted_s   = tick_s && busy;
    limit_hit_s = counted_s && (max_cycles != CNT_ZERO) &&
                  (({1'b0, count_q} + CMP_ONE) == {1'b0, max_cycles});
  end

  // Next-state logic: stop beats halt beats limit beats step completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else if (step) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else if (limit_hit_s) begin
          state_d = ST_HALTED;
        end else if ((state_q == ST_STEP) && tick_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_HALTED: begin
        if (clr) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Prescaler, cycle counter and timeout flag next values.
  always_comb begin
    pcnt_d    = pcnt_q;
    count_d   = count_q;
    timeout_d = timeout_q;

    // Prescaler restarts on every state entry and idles outside RUN/STEP.
    if ((state_d != state_q) || !active_s) begin
      pcnt_d = PCNT_ZERO;
    end else if (pcnt_q == PCNT_LAST) begin
      pcnt_d = PCNT_ZERO;
    end else begin
      pcnt_d = pcnt_q + PCNT_ONE;
    end

    // clr wins over a coincident counted tick.
    if (clr) begin
      count_d   = CNT_ZERO;
      timeout_d = 1'b0;
    end else if (counted_s) begin
      count_d = sat_inc(count_q);
      if (limit_hit_s) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
    end else begin
      count_d   = count_q;
      timeout_d = timeout_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pcnt_q    <= PCNT_ZERO;
      count_q   <= CNT_ZERO;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign clk_en      = tick_s;
  assign running     = active_s;
  assign done        = (state_q == ST_HALTED);
  assign timeout     = timeout_q;
  assign cycle_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl with DIV=4.
// A second instance with CW=4 covers counter saturation.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic        clr = 1'b0;
  logic        busy = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] max_cycles = 32'd0;
  logic [3:0]  max_cycles4 = 4'd0;

  logic        clk_en, running, done, timeout;
  logic [31:0] cycle_count;
  logic [1:0]  state;
  logic        clk_en4, running4, done4, timeout4;
  logic [3:0]  cycle_count4;
  logic [1:0]  state4;

  int checks = 0;
  int errors = 0;

  run_ctrl #(.DIV(4), .CW(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .clr(clr), .busy(busy), .halt(halt), .max_cycles(max_cycles),
    .clk_en(clk_en), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .state(state)
  );

  run_ctrl #(.DIV(4), .CW(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .clr(clr), .busy(busy), .halt(halt), .max_cycles(max_cycles4),
    .clk_en(clk_en4), .running(running4), .done(done4), .timeout(timeout4),
    .cycle_count(cycle_count4), .state(state4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Advance to 1ns after the next rising edge.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    clr = 1'b0; busy = 1'b0; halt = 1'b0; max_cycles = 32'd0;
    step_clk();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; step = 1'b1; busy = 1'b1; halt = 1'b1;
    step_clk();
    step_clk();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cycle_count); end
    checks++; if ({clk_en, running, done, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {clk_en, running, done, timeout}); end
    start = 1'b0; step = 1'b0; busy = 1'b0; halt = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_free_run();
    logic [31:0] mask;
    do_reset();
    busy = 1'b1; start = 1'b1;
    step_clk();
    start = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL fr_enter got %0d exp 1", state); end
    mask = 32'd0;
    for (int k = 1; k <= 19; k++) begin
      if (clk_en === 1'b1) mask[k] = 1'b1;
      step_clk();
    end
    checks++; if (mask !== 32'h0001_1110) begin errors++; $display("FAIL fr_ticks got %h exp 00011110", mask); end
    checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL fr_count got %0d exp 4", cycle_count); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL fr_running got %b exp 1", running); end
  endtask

  task automatic test_step();
    logic [31:0] mask;
    do_reset();
    busy = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      step = 1'b1;
      step_clk();
      step = 1'b0;
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL st_enter got %0d exp 2", state); end
      mask = 32'd0;
      for (int k = 1; k <= 8; k++) begin
        if (clk_en === 1'b1) mask[k] = 1'b1;
        step_clk();
      end
      checks++; if (mask !== 32'h0000_0010) begin errors++; $display("FAIL st_ticks got %h exp 00000010", mask); end
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL st_idle got %0d exp 0", state); end
      checks++; if (cycle_count !== 32'(n)) begin errors++; $display("FAIL st_count got %0d exp %0d", cycle_count, n); end
    end
  endtask

  task automatic test_limit();
    do_reset();
    max_cycles = 32'd3; busy = 1'b1; start = 1'b1;
    step_clk();
    start = 1'b0;
    repeat (12) step_clk();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL lim_state got %0d exp 3", state); end
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL lim_count got %0d exp 3", cycle_count); end
    checks++; if ({timeout, done, running} !== 3'b110) begin errors++; $display("FAIL lim_flags got %b exp 110", {timeout, done, running}); end
    start = 1'b1; step = 1'b1; stop = 1'b1;
    repeat (6) step_clk();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL lim_ignore got %0d exp 3", state); end
    start = 1'b0; step = 1'b0; stop = 1'b0;
    clr = 1'b1;
    step_clk();
    clr = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL lim_clr_state got %0d exp 0", state); end
    checks++; if ({cycle_count, timeout} !== {32'd0, 1'b0}) begin errors++; $display("FAIL lim_clr got %0d/%b exp 0/0", cycle_count, timeout); end
  endtask

  task automatic test_stop_halt();
    do_reset();
    busy = 1'b1; start = 1'b1;
    step_clk();
    start = 1'b0;
    repeat (7) step_clk();
    stop = 1'b1;
    #1;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL sh_stop_tick got %b exp 0", clk_en); end
    step_clk();
    stop = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL sh_stop_state got %0d exp 0", state); end
    checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL sh_stop_count got %0d exp 1", cycle_count); end
    start = 1'b1;
    step_clk();
    start = 1'b0;
    clr = 1'b1;
    step_clk();
    clr = 1'b0;
    checks++; if ({state, cycle_count} !== {2'd1, 32'd0}) begin errors++; $display("FAIL sh_clr_run got %0d/%0d exp 1/0", state, cycle_count); end
    repeat (2) step_clk();
    halt = 1'b1;
    #1;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL sh_halt_tick got %b exp 1", clk_en); end
    step_clk();
    halt = 1'b0;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL sh_halt_state got %0d exp 3", state); end
    checks++; if ({cycle_count, timeout} !== {32'd1, 1'b0}) begin errors++; $display("FAIL sh_halt_count got %0d/%b exp 1/0", cycle_count, timeout); end
  endtask

  task automatic test_busy_sat();
    do_reset();
    start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      busy = (p % 2 == 0) ? 1'b1 : 1'b0;
      repeat (4) step_clk();
    end
    checks++; if (cycle_count4 !== 4'd2) begin errors++; $display("FAIL bs_gate got %0d exp 2", cycle_count4); end
    busy = 1'b1;
    repeat (52) step_clk();
    checks++; if (cycle_count4 !== 4'd15) begin errors++; $display("FAIL bs_reach got %0d exp 15", cycle_count4); end
    repeat (12) step_clk();
    checks++; if (cycle_count4 !== 4'd15) begin errors++; $display("FAIL bs_sat got %0d exp 15", cycle_count4); end
    checks++; if ({state4, timeout4} !== {2'd1, 1'b0}) begin errors++; $display("FAIL bs_state got %0d/%b exp 1/0", state4, timeout4); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] mask;
    do_reset();
    busy = 1'b1; start = 1'b1;
    step_clk();
    start = 1'b0;
    repeat (6) step_clk();
    checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL rm_pre got %0d exp 1", cycle_count); end
    rst = 1'b0;
    step_clk();
    rst = 1'b1;
    checks++; if ({state, cycle_count} !== {2'd0, 32'd0}) begin errors++; $display("FAIL rm_state got %0d/%0d exp 0/0", state, cycle_count); end
    checks++; if ({clk_en, running, done, timeout} !== 4'b0000) begin errors++; $display("FAIL rm_flags got %b exp 0000", {clk_en, running, done, timeout}); end
    mask = 32'd0;
    for (int k = 1; k <= 5; k++) begin
      if (clk_en === 1'b1) mask[k] = 1'b1;
      step_clk();
    end
    start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (clk_en === 1'b1) mask[k + 8] = 1'b1;
      step_clk();
    end
    checks++; if (mask !== 32'h0000_1000) begin errors++; $display("FAIL rm_restart got %h exp 00001000", mask); end
    repeat (3) step_clk();
    rst = 1'b0;
    #1;
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL rm_rst_tick got %b exp 0", clk_en); end
    step_clk();
    rst = 1'b1;
    #1;
    checks++; if ({clk_en, state, cycle_count} !== {1'b0, 2'd0, 32'd0}) begin errors++; $display("FAIL rm_after got %b/%0d/%0d exp 0/0/0", clk_en, state, cycle_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mask;
    do_reset();
    start = 1'b1; step = 1'b1;
    step_clk();
    step = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL bb_start_wins got %0d exp 1", state); end
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL bb_stop got %0d exp 0", state); end
    step_clk();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL bb_reenter got %0d exp 1", state); end
    do_reset();
    step = 1'b1;
    step_clk();
    mask = 32'd0;
    for (int k = 1; k <= 10; k++) begin
      if (clk_en === 1'b1) mask[k] = 1'b1;
      step_clk();
    end
    step = 1'b0;
    checks++; if (mask !== 32'h0000_0210) begin errors++; $display("FAIL bb_step_held got %h exp 00000210", mask); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step();
    test_limit();
    test_stop_halt();
    test_busy_sat();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
